branch_resolution_unit: RTL
===========================

Name: branch_resolution_unit

Overview:
- Parametrised successor to the combinational branch resolution logic.
- Adds an on-chip pattern history table of saturating counters indexed by PC XOR global history (gshare), a non-speculative global history register, a post-mispredict squash FSM and saturating performance counters.
- Predicts at fetch and resolves branch/JSR/TRAP/JMP at the resolve stage.
- Drives the PC mux override, pipeline reset and BTB target select.

Parameters:
- PC_WIDTH, 16, width of fetch PC.
- PHT_INDEX_BITS, 6, log2 of PHT entries (64 entries).
- GHR_BITS, 4, global history length; must be <= PHT_INDEX_BITS.
- CTR_BITS, 2, saturating counter width per PHT entry.
- FLUSH_CYCLES, 2, squash cycles after a redirect; range 1..15.
- PERF_WIDTH, 16, width of performance counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_pc  in  PC_WIDTH  PC of the instruction being fetched.
- fetch_btb_valid  in  1  BTB hit for fetch_pc.
- fetch_pred_taken  out  1  MSB of indexed PHT counter.
- fetch_pht_index  out  PHT_INDEX_BITS  lookup index, carried down the pipeline.
- res_valid  in  1  resolve-stage instruction valid.
- res_opcode  in  4  lc3b_opcode of the resolving instruction.
- res_branch_enable  in  1  condition codes satisfied.
- res_spec_taken  in  1  instruction was fetched down the predicted-taken path.
- res_incorrect_target  in  1  BTB target mismatch.
- res_pht_index  in  PHT_INDEX_BITS  index carried from fetch.
- res_pcmux_sel  in  3  datapath pcmux select.
- pcmux_sel_updated  out  3  final PC mux select.
- btb_target_mux_sel  out  2  BTB fill source.
- require_reset  out  1  redirect pulse.
- squash  out  1  high while FSM in FLUSH.
- perf_branches  out  PERF_WIDTH  count of resolved conditional branches.
- perf_mispredicts  out  PERF_WIDTH  count of redirects.

Behaviour:
- Reset:
  - All PHT entries = weakly-not-taken (2^(CTR_BITS-1) - 1; 01 for CTR_BITS=2).
  - GHR = 0, FSM = IDLE, perf counters = 0.
  - require_reset = 0, squash = 0.
  - Reset mid-FLUSH returns the FSM to IDLE next cycle.
- Lookup (combinational):
  - fetch_pht_index = fetch_pc[PHT_INDEX_BITS:1] XOR zero-extended GHR.
  - fetch_pred_taken = counter MSB.
  - Same-cycle read and update of the same entry returns the old value.
- Resolution classes (evaluated only when res_valid && FSM == IDLE):
  - Conditional branch (op_br): correctly/incorrectly taken/not-taken from res_spec_taken vs res_branch_enable.
  - Unconditional: op_jsr, op_trap, op_jmp.
- Priority (first match wins):
  1. Incorrectly not-taken: require_reset = 1, pcmux = 001, btb_sel = 00.
  2. Incorrectly taken: require_reset = 1, pcmux = 110.
  3. Unconditional with (res_incorrect_target || !res_spec_taken): require_reset = 1, pcmux = res_pcmux_sel; btb_sel = jmp 10, trap 01, jsr 00 if res_pcmux_sel == 001 else 10.
  4. Correct op_br: pcmux = 011.
  5. Otherwise: pcmux = res_pcmux_sel, btb_sel = 00.
- Fetch override: if !require_reset && fetch_pred_taken && fetch_btb_valid, pcmux = 101.
- PHT/GHR update, one cycle after resolve, on every valid IDLE op_br:
  - Counter [res_pht_index] +1 if res_branch_enable, else -1, saturating at 0 and 2^CTR_BITS - 1.
  - GHR <= {GHR[GHR_BITS-2:0], res_branch_enable}.
- FSM:
  - IDLE -> FLUSH on require_reset; count loaded with FLUSH_CYCLES.
  - FLUSH: squash = 1, res_valid ignored (no redirect, no PHT/GHR/perf update), count decrements.
  - FLUSH -> IDLE when count reaches 1. A resolve presented on the IDLE cycle after exit is processed.
- Performance counters:
  - perf_branches += 1 per IDLE valid op_br.
  - perf_mispredicts += 1 per require_reset.
  - Both saturate at all-ones, no wrap.
- Outside IDLE or when !res_valid: require_reset = 0, btb_sel = 00, pcmux = res_pcmux_sel subject to the fetch override.

Test Plan:
1. Reset, then fetch_pc = 0x0040 with GHR = 0 -> fetch_pht_index = 0x20, fetch_pred_taken = 0; perf counters 0.
2. Three taken op_br on index 5 (res_spec_taken = 0 each):
   - First resolve: require_reset = 1, pcmux = 001, squash high for exactly 2 cycles.
   - Counter 01 -> 10 -> 11 -> 11 (saturates); GHR = 0111; perf_mispredicts = 3.
3. op_br with res_spec_taken = 1, branch_enable = 0 -> pcmux = 110, require_reset = 1. A second mispredict during FLUSH is ignored: no second pulse, perf unchanged.
4. Unconditional branches with res_incorrect_target = 1:
   - op_trap -> btb_sel = 01.
   - op_jsr with res_pcmux_sel = 001 -> btb_sel = 00.
   - op_jmp -> btb_sel = 10.
   - pcmux passes res_pcmux_sel in all three.
5. Correctly predicted op_br with fetch_pred_taken = 1 and fetch_btb_valid = 1 -> pcmux = 101, no reset; perf_branches increments, perf_mispredicts does not.
6. Preload perf_mispredicts to 0xFFFF, force a mispredict -> holds 0xFFFF. Assert reset during FLUSH -> squash = 0 next cycle, all PHT counters = 01.

Source files
------------

// File: rtl/branch_resolution_unit.sv
// ---------------------------------------------------------------------------
// branch_resolution_unit
//
// Gshare branch predictor plus branch/JSR/TRAP/JMP resolution for the LC-3b
// pipeline. Fetch looks up a pattern history table (PHT) of saturating
// counters indexed by PC XOR global history. At the resolve stage each
// control-flow instruction is classified and, when the pipeline went the
// wrong way, a one-cycle redirect pulse is raised and a short squash window
// follows. PHT, global history and performance counters are updated
// non-speculatively from resolved conditional branches only.
//
// Handshake: the resolve port is a qualifier-only interface. A resolve is
// consumed on every rising clk edge where res_valid is high and the unit is
// in IDLE; there is no ready/back-pressure. While squashing, res_valid is
// ignored and the instruction is dropped.
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   fetch_pc               PC being fetched
//   fetch_btb_valid        BTB hit for fetch_pc
//   fetch_pred_taken       MSB of the indexed PHT counter
//   fetch_pht_index        lookup index, carried down the pipeline
//   res_valid              resolve-stage instruction valid
//   res_opcode             LC-3b opcode of the resolving instruction
//   res_branch_enable      condition codes satisfied (actual direction)
//   res_spec_taken         instruction was fetched down predicted-taken path
//   res_incorrect_target   BTB target mismatch
//   res_pht_index          PHT index carried from fetch
//   res_pcmux_sel          datapath PC mux select
//   pcmux_sel_updated      final PC mux select
//   btb_target_mux_sel     BTB fill source
//   require_reset          redirect pulse (pipeline reset)
//   squash                 high while the squash window is open
//   perf_branches          saturating count of resolved conditional branches
//   perf_mispredicts       saturating count of redirects
//   dbg_state              FSM state (0 = IDLE, 1 = FLUSH)
// ---------------------------------------------------------------------------
module branch_resolution_unit #(
  parameter int PC_WIDTH       = 16,
  parameter int PHT_INDEX_BITS = 6,
  parameter int GHR_BITS       = 4,
  parameter int CTR_BITS       = 2,
  parameter int FLUSH_CYCLES   = 2,
  parameter int PERF_WIDTH     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PC_WIDTH-1:0]       fetch_pc,
  input  logic                      fetch_btb_valid,
  output logic                      fetch_pred_taken,
  output logic [PHT_INDEX_BITS-1:0] fetch_pht_index,
  input  logic                      res_valid,
  input  logic [3:0]                res_opcode,
  input  logic                      res_branch_enable,
  input  logic                      res_spec_taken,
  input  logic                      res_incorrect_target,
  input  logic [PHT_INDEX_BITS-1:0] res_pht_index,
  input  logic [2:0]                res_pcmux_sel,
  output logic [2:0]                pcmux_sel_updated,
  output logic [1:0]                btb_target_mux_sel,
  output logic                      require_reset,
  output logic                      squash,
  output logic [PERF_WIDTH-1:0]     perf_branches,
  output logic [PERF_WIDTH-1:0]     perf_mispredicts,
  output logic                      dbg_state
);

  localparam int PHT_ENTRIES = 1 << PHT_INDEX_BITS;

  // Weakly-not-taken: one below the taken threshold.
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_MIN  = '0;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  localparam logic [PERF_WIDTH-1:0] PERF_MAX = {PERF_WIDTH{1'b1}};

  // LC-3b opcodes of interest.
  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  // PC mux encodings driven by this unit.
  localparam logic [2:0] PCMUX_BR_TARGET = 3'b001;
  localparam logic [2:0] PCMUX_CORRECT   = 3'b011;
  localparam logic [2:0] PCMUX_BTB       = 3'b101;
  localparam logic [2:0] PCMUX_RECOVER   = 3'b110;

  // BTB fill source encodings.
  localparam logic [1:0] BTB_SEL_ADDER = 2'b00;
  localparam logic [1:0] BTB_SEL_TRAP  = 2'b01;
  localparam logic [1:0] BTB_SEL_REG   = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t state_q, state_next;
  logic [3:0] flush_cnt_q, flush_cnt_next;

  logic [CTR_BITS-1:0] pht_q [PHT_ENTRIES];
  logic [GHR_BITS-1:0] ghr_q;

  // -------------------------------------------------------------------------
  // Fetch-side lookup. The array write happens on the clock edge, so a read
  // of an entry being updated in the same cycle sees the old counter.
  // -------------------------------------------------------------------------
  assign fetch_pht_index  = fetch_pc[PHT_INDEX_BITS:1] ^ PHT_INDEX_BITS'(ghr_q);
  assign fetch_pred_taken = pht_q[fetch_pht_index][CTR_BITS-1];

  // PC bits that do not participate in indexing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[PC_WIDTH-1:PHT_INDEX_BITS+1], fetch_pc[0]};

  // -------------------------------------------------------------------------
  // Resolve-stage classification
  // -------------------------------------------------------------------------
  logic res_active;
  logic is_br;
  logic is_uncond;
  logic br_wrong_not_taken;
  logic br_wrong_taken;
  logic uncond_redirect;
  logic br_correct;
  logic br_update;

  always_comb begin
    res_active         = res_valid && (state_q == ST_IDLE) && !reset;
    is_br              = (res_opcode == OP_BR);
    is_uncond          = (res_opcode == OP_JSR) || (res_opcode == OP_TRAP) ||
                         (res_opcode == OP_JMP);
    br_update          = res_active && is_br;
    br_wrong_not_taken = br_update && res_branch_enable && !res_spec_taken;
    br_wrong_taken     = br_update && res_spec_taken && !res_branch_enable;
    br_correct         = br_update && !br_wrong_not_taken && !br_wrong_taken;
    uncond_redirect    = res_active && is_uncond &&
                         (res_incorrect_target || !res_spec_taken);
  end

  // -------------------------------------------------------------------------
  // Redirect / PC mux / BTB source selection (first match wins)
  // -------------------------------------------------------------------------
  always_comb begin
    require_reset      = 1'b0;
    pcmux_sel_updated  = res_pcmux_sel;
    btb_target_mux_sel = BTB_SEL_ADDER;

    if (br_wrong_not_taken) begin
      require_reset     = 1'b1;
      pcmux_sel_updated = PCMUX_BR_TARGET;
    end else if (br_wrong_taken) begin
      require_reset     = 1'b1;
      pcmux_sel_updated = PCMUX_RECOVER;
    end else if (uncond_redirect) begin
      require_reset     = 1'b1;
      pcmux_sel_updated = res_pcmux_sel;
      case (res_opcode)
        OP_JMP:  btb_target_mux_sel = BTB_SEL_REG;
        OP_TRAP: btb_target_mux_sel = BTB_SEL_TRAP;
        // JSR with PC-relative target fills from the adder, JSRR from a register.
        OP_JSR:  btb_target_mux_sel = (res_pcmux_sel == PCMUX_BR_TARGET) ?
                                      BTB_SEL_ADDER : BTB_SEL_REG;
        default: btb_target_mux_sel = BTB_SEL_ADDER;
      endcase
    end else if (br_correct) begin
      pcmux_sel_updated = PCMUX_CORRECT;
    end

    // A predicted-taken BTB hit steers fetch unless a redirect is in flight.
    if (!require_reset && fetch_pred_taken && fetch_btb_valid) begin
      pcmux_sel_updated = PCMUX_BTB;
    end
  end

  // -------------------------------------------------------------------------
  // Squash FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_next;
      flush_cnt_q <= flush_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_q;
    flush_cnt_next = flush_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (require_reset) begin
          state_next     = ST_FLUSH;
          flush_cnt_next = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        // The cycle holding a count of 1 is the last squash cycle.
        if (flush_cnt_q <= 4'd1) begin
          state_next     = ST_IDLE;
          flush_cnt_next = '0;
        end else begin
          flush_cnt_next = flush_cnt_q - 4'd1;
        end
      end
      default: begin
        state_next     = ST_IDLE;
        flush_cnt_next = '0;
      end
    endcase
  end

  assign squash    = (state_q == ST_FLUSH);
  assign dbg_state = state_q;

  // -------------------------------------------------------------------------
  // PHT and global history, trained by resolved conditional branches only
  // -------------------------------------------------------------------------
  logic [CTR_BITS-1:0] ctr_cur;
  logic [CTR_BITS-1:0] ctr_new;

  always_comb begin
    ctr_cur = pht_q[res_pht_index];
    ctr_new = ctr_cur;
    if (res_branch_enable) begin
      if (ctr_cur != CTR_MAX) ctr_new = ctr_cur + 1'b1;
    end else begin
      if (ctr_cur != CTR_MIN) ctr_new = ctr_cur - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PHT_ENTRIES; i++) begin
        pht_q[i] <= CTR_INIT;
      end
    end else if (br_update) begin
      pht_q[res_pht_index] <= ctr_new;
    end
  end

  // Shift in the actual outcome; the cast drops the oldest history bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q <= '0;
    end else if (br_update) begin
      ghr_q <= GHR_BITS'({ghr_q, res_branch_enable});
    end
  end

  // -------------------------------------------------------------------------
  // Saturating performance counters
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (br_update && (perf_branches != PERF_MAX)) begin
        perf_branches <= perf_branches + 1'b1;
      end
      if (require_reset && (perf_mispredicts != PERF_MAX)) begin
        perf_mispredicts <= perf_mispredicts + 1'b1;
      end
    end
  end

endmodule
